// File: rtl/bus_pkg.sv
// Shared definitions for the inter-stage pipeline buses: packet layouts,
// default queue depths, the queue state encoding and modulo pointer stepping.
package bus_pkg;

  localparam int unsigned BUS_DATA_W             = 64;
  localparam int unsigned STORE_TO_FETCH_DEPTH   = 4;
  localparam int unsigned EXECUTE_TO_STORE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } store_to_fetch_packet_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
    logic [7:0]  rd;
    logic [3:0]  byte_en;
    logic [3:0]  op;
  } execute_to_store_packet_t;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } queue_state_t;

  // Wraps at depth-1 explicitly so non-power-of-two depths step correctly.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    if (ptr >= depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/bus_queue_ptr.sv
// Queue pointer register: clear has priority over advance, and advancing
// wraps modulo DEPTH (constant 0 when DEPTH is 1).
module bus_queue_ptr
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Pointer register with synchronous reset/clear and modulo advance.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= PTR_W'(next_ptr(32'(r_ptr), DEPTH));
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/stage_bus_queue.sv
// In-order DEPTH-entry queue between two pipeline stages with valid/ready on
// both sides, occupancy count, almost-full hint, flush and sticky error flags.
module stage_bus_queue
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              recv_valid,
  output logic [DATA_W-1:0] recv_data,
  input  logic              recv_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  queue_state_t      r_state;
  queue_state_t      w_state_nxt;
  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic              w_push;
  logic              w_pop;
  logic              w_send_ready;
  logic              w_recv_valid;
  logic              r_err_overflow;
  logic              r_err_underflow;

  // Handshake flags come straight from the state register, so there is
  // no combinational path from the send side to the recv side.
  assign w_send_ready = (r_state != Q_FULL);
  assign w_recv_valid = (r_state != Q_EMPTY);
  assign w_push       = send_valid & w_send_ready;
  assign w_pop        = w_recv_valid & recv_ready;

  bus_queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (flush),
    .i_en    (w_push),
    .o_ptr   (w_wr_ptr)
  );

  bus_queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (flush),
    .i_en    (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  // Next occupancy and state: flush beats push/pop; push+pop leaves count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1'b1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1'b1);
    end else begin
      w_count_nxt = r_count;
    end
    if (w_count_nxt == '0) begin
      w_state_nxt = Q_EMPTY;
    end else if (w_count_nxt == CNT_W'(DEPTH)) begin
      w_state_nxt = Q_FULL;
    end else begin
      w_state_nxt = Q_PARTIAL;
    end
  end

  // State and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= Q_EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Sticky protocol-error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_err_overflow  <= r_err_overflow | (send_valid & ~w_send_ready);
      r_err_underflow <= r_err_underflow | (recv_ready & ~w_recv_valid);
    end
  end

  // Storage write; a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[w_wr_ptr] <= send_data;
    end
  end

  assign send_ready    = w_send_ready;
  assign recv_valid    = w_recv_valid;
  assign recv_data     = r_mem[w_rd_ptr];
  assign count         = r_count;
  assign almost_full   = (r_count >= CNT_W'(AFULL_LVL));
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_stage_bus_queue.sv
// Self-checking bench: table-driven vectors on a DEPTH=4 queue with a data
// scoreboard, plus a hand-written wrap sequence on a DEPTH=3 queue.
module tb_stage_bus_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance signals
  logic       reset4, flush4, sv4, rr4;
  logic [7:0] sd4;
  logic       sr4, rv4, af4, ovf4, udf4;
  logic [7:0] rd4;
  logic [2:0] count4;

  // DEPTH=3 instance signals
  logic       reset3, flush3, sv3, rr3;
  logic [7:0] sd3;
  logic       sr3, rv3, af3, ovf3, udf3;
  logic [7:0] rd3;
  logic [1:0] count3;

  stage_bus_queue #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset4), .flush(flush4),
    .send_valid(sv4), .send_data(sd4), .send_ready(sr4),
    .recv_valid(rv4), .recv_data(rd4), .recv_ready(rr4),
    .count(count4), .almost_full(af4),
    .err_overflow(ovf4), .err_underflow(udf4)
  );

  stage_bus_queue #(.DATA_W(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset3), .flush(flush3),
    .send_valid(sv3), .send_data(sd3), .send_ready(sr3),
    .recv_valid(rv3), .recv_data(rd3), .recv_ready(rr3),
    .count(count3), .almost_full(af3),
    .err_overflow(ovf3), .err_underflow(udf3)
  );

  typedef struct {
    logic       rst, fl, sv;
    logic [7:0] d;
    logic       rr;
    logic [2:0] cnt;
    logic       rv, sr, af, ovf, udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb4[$];
  logic [7:0] sb3[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic vec_t mk(input logic rst, input logic fl, input logic sv,
                              input logic [7:0] d, input logic rr, input logic [2:0] cnt,
                              input logic rv, input logic sr, input logic af,
                              input logic ovf, input logic udf);
    vec_t v;
    v.rst = rst; v.fl = fl; v.sv = sv; v.d = d; v.rr = rr;
    v.cnt = cnt; v.rv = rv; v.sr = sr; v.af = af; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outputs are state-only, so checking #1 after driving at negedge sees pre-edge state.
  task automatic apply(input vec_t v, input int idx);
    logic [7:0] e;
    @(negedge clk);
    reset4 = v.rst; flush4 = v.fl; sv4 = v.sv; sd4 = v.d; rr4 = v.rr;
    #1;
    chk($sformatf("v%0d count", idx),       64'(count4), 64'(v.cnt));
    chk($sformatf("v%0d recv_valid", idx),  64'(rv4),    64'(v.rv));
    chk($sformatf("v%0d send_ready", idx),  64'(sr4),    64'(v.sr));
    chk($sformatf("v%0d almost_full", idx), 64'(af4),    64'(v.af));
    chk($sformatf("v%0d err_overflow", idx),  64'(ovf4), 64'(v.ovf));
    chk($sformatf("v%0d err_underflow", idx), 64'(udf4), 64'(v.udf));
    if (v.rv && v.rr && !v.rst) begin
      if (sb4.size() == 0) begin
        chk($sformatf("v%0d scoreboard empty on pop", idx), 64'd1, 64'd0);
      end else begin
        e = sb4.pop_front();
        chk($sformatf("v%0d recv_data", idx), 64'(rd4), 64'(e));
      end
    end
    if (v.rst || v.fl) sb4.delete();
    else if (v.sv && v.sr) sb4.push_back(v.d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    reset4 = 1'b1; flush4 = 1'b0; sv4 = 1'b0; sd4 = 8'h00; rr4 = 1'b0;
    reset3 = 1'b1; flush3 = 1'b0; sv3 = 1'b0; sd3 = 8'h00; rr3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset4 = 1'b0; reset3 = 1'b0;
    #1;
    chk("reset count", 64'(count4), 64'd0);
    chk("reset recv_valid", 64'(rv4), 64'd0);
    chk("reset send_ready", 64'(sr4), 64'd1);
    chk("reset almost_full", 64'(af4), 64'd0);
    chk("reset err_overflow", 64'(ovf4), 64'd0);
    chk("reset err_underflow", 64'(udf4), 64'd0);

    // Fill to full, overflow attempt, drain in order.
    //             rst   fl    sv    d      rr    cnt   rv    sr    af    ovf   udf
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    // Streaming push+pop, data 0..9, pointers wrap.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k < 10; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'(k), 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    // Flush with simultaneous push: 0xFF must never appear.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    // Flush with simultaneous pop: head delivered, then empty.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hD2, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    // Underflow, then reset clears it.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // DEPTH=3: interleaved push/pop, write pointer must run 0,1,2,0,1,2,0.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sv3 = 1'b1; sd3 = 8'(8'h30 + i); rr3 = 1'b0;
      #1;
      chk($sformatf("d3 push%0d count", i), 64'(count3), 64'd0);
      chk($sformatf("d3 push%0d wr_ptr", i), 64'(dut3.u_wr_ptr.o_ptr), 64'(i % 3));
      sb3.push_back(sd3);
      @(negedge clk);
      sv3 = 1'b0; rr3 = 1'b1;
      #1;
      chk($sformatf("d3 pop%0d recv_valid", i), 64'(rv3), 64'd1);
      chk($sformatf("d3 pop%0d count", i), 64'(count3), 64'd1);
      e = sb3.pop_front();
      chk($sformatf("d3 pop%0d recv_data", i), 64'(rd3), 64'(e));
    end
    @(negedge clk);
    rr3 = 1'b0;
    #1;
    chk("d3 final count", 64'(count3), 64'd0);
    chk("d3 final err_underflow", 64'(udf3), 64'd0);
    chk("d3 final err_overflow", 64'(ovf3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
